rf_scrubber: RTL and testbench



---
 rtl/rf_scrubber_pkg.sv | 21 ++
 rtl/rf_scrubber_sat_counter.sv | 35 +++
 rtl/rf_scrubber.sv | 178 +++++++++++++++++
 tb/tb_rf_scrubber.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_scrubber_pkg.sv
// Shared types and helpers for the register-file scrubber.
package p_hardisc;

   typedef logic [4:0] rf_add;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WAITFIX,
      VERIFY
   } scrub_state;

   localparam rf_add RF_FIRST = 5'd1;
   localparam rf_add RF_LAST  = 5'd31;

   // x0 is hard-wired zero, so the walk wraps from x31 straight back to x1.
   function automatic rf_add next_add(input rf_add a);
      return (a == RF_LAST) ? RF_FIRST : a + 5'd1;
   endfunction

endpackage

// File: rtl/rf_scrubber_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter
   import p_hardisc::*;
#(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         resetn_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/rf_scrubber.sv
// Background scrubber for the SEC-DED register file: borrows idle read-port-2 cycles to walk x1..x31.
// Optional post-repair re-read of the target is built in with `define HARDISC_SCRUB_VERIFY_EN.
module rf_scrubber
   import p_hardisc::*;
#(
   parameter int unsigned INTERVAL    = 16,
   parameter int unsigned FIX_TIMEOUT = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             s_clk_i,
   input  logic             s_resetn_i,
   input  logic             s_en_i,
   input  logic             s_clr_i,
   input  logic             s_p2_busy_i,
   input  logic [4:0]       s_p2_add_i,
   output logic [4:0]       s_rp2_add_o,
   output logic             s_scrub_o,
   input  logic             s_ce_i,
   input  logic             s_uce_i,
   input  logic             s_rf_we_i,
   input  logic [4:0]       s_rf_wadd_i,
   output logic [CNT_W-1:0] s_ce_cnt_o,
   output logic             s_uce_o,
   output logic [4:0]       s_uce_add_o,
   output logic             s_pass_o
);

   localparam int unsigned IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam int unsigned TW = (FIX_TIMEOUT > 1) ? $clog2(FIX_TIMEOUT) : 1;
   localparam logic [IW-1:0] IVL_LAST = IW'(INTERVAL - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(FIX_TIMEOUT - 1);

   scrub_state    state_d, state_q;
   rf_add         ptr_d, ptr_q;
   rf_add         tgt_d, tgt_q;
   rf_add         uce_add_d, uce_add_q;
   logic [IW-1:0] ivl_d, ivl_q;
   logic [TW-1:0] tmo_d, tmo_q;
   logic          uce_d, uce_q;
   logic          pass_d, pass_q;
   logic          scrub;
   logic          advance;
   logic          cnt_inc;
   logic          uce_set;
   rf_add         uce_src;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      tgt_d     = tgt_q;
      ivl_d     = ivl_q;
      tmo_d     = tmo_q;
      uce_d     = uce_q;
      uce_add_d = uce_add_q;
      pass_d    = 1'b0;
      scrub     = 1'b0;
      advance   = 1'b0;
      cnt_inc   = 1'b0;
      uce_set   = 1'b0;
      uce_src   = ptr_q;

      case (state_q)
         IDLE: begin
            if (!s_en_i) begin
               ivl_d = '0;
            end else if (ivl_q == IVL_LAST) begin
               ivl_d   = '0;
               state_d = READ;
            end else begin
               ivl_d = ivl_q + IW'(1);
            end
         end
         READ: begin
            if (!s_p2_busy_i) begin
               scrub = 1'b1;
               if (s_uce_i) begin
                  uce_set = 1'b1;
                  advance = 1'b1;
                  state_d = IDLE;
               end else if (s_ce_i) begin
                  tgt_d   = ptr_q;
                  tmo_d   = '0;
                  state_d = WAITFIX;
               end else begin
                  advance = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAITFIX: begin
            // Any write to the target clears the error, ACM repair or pipeline writeback alike.
            if (s_rf_we_i && (s_rf_wadd_i == tgt_q)) begin
               cnt_inc = 1'b1;
`ifdef HARDISC_SCRUB_VERIFY_EN
               state_d = VERIFY;
`else
               advance = 1'b1;
               state_d = IDLE;
`endif
            end else if (tmo_q == TMO_LAST) begin
               advance = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
`ifdef HARDISC_SCRUB_VERIFY_EN
         VERIFY: begin
            // Pointer is not advanced until here, so the re-read address equals the target.
            if (!s_p2_busy_i) begin
               scrub = 1'b1;
               if (s_ce_i || s_uce_i) begin
                  uce_set = 1'b1;
                  uce_src = tgt_q;
               end
               advance = 1'b1;
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      if (advance) begin
         ptr_d  = next_add(ptr_q);
         pass_d = (ptr_q == RF_LAST);
      end
      if (uce_set) begin
         uce_d = 1'b1;
         if (!uce_q) begin
            uce_add_d = uce_src;
         end
      end
      if (s_clr_i) begin
         uce_d     = 1'b0;
         uce_add_d = '0;
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (!s_resetn_i) begin
         state_q   <= IDLE;
         ptr_q     <= RF_FIRST;
         tgt_q     <= RF_FIRST;
         ivl_q     <= '0;
         tmo_q     <= '0;
         uce_q     <= 1'b0;
         uce_add_q <= '0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         tgt_q     <= tgt_d;
         ivl_q     <= ivl_d;
         tmo_q     <= tmo_d;
         uce_q     <= uce_d;
         uce_add_q <= uce_add_d;
         pass_q    <= pass_d;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_ce_cnt (
      .clk_i    (s_clk_i),
      .resetn_i (s_resetn_i),
      .inc_i    (cnt_inc),
      .clr_i    (s_clr_i),
      .cnt_o    (s_ce_cnt_o)
   );

   assign s_scrub_o   = scrub;
   assign s_rp2_add_o = scrub ? ptr_q : s_p2_add_i;
   assign s_uce_o     = uce_q;
   assign s_uce_add_o = uce_add_q;
   assign s_pass_o    = pass_q;

endmodule

// File: tb/tb_rf_scrubber.sv
// Directed self-checking bench for rf_scrubber (INTERVAL=16, FIX_TIMEOUT=4, 4-bit counter).
module tb_rf_scrubber;

   logic       clk;
   logic       resetn, en, clr, busy, ce, uce, we;
   logic [4:0] p2_add, wadd, rp2_add, uce_add;
   logic       scrub, uce_flag, pass;
   logic [3:0] ce_cnt;

   int checks = 0;
   int failures = 0;

   rf_scrubber #(
      .INTERVAL    (16),
      .FIX_TIMEOUT (4),
      .CNT_W       (4)
   ) dut (
      .s_clk_i     (clk),
      .s_resetn_i  (resetn),
      .s_en_i      (en),
      .s_clr_i     (clr),
      .s_p2_busy_i (busy),
      .s_p2_add_i  (p2_add),
      .s_rp2_add_o (rp2_add),
      .s_scrub_o   (scrub),
      .s_ce_i      (ce),
      .s_uce_i     (uce),
      .s_rf_we_i   (we),
      .s_rf_wadd_i (wadd),
      .s_ce_cnt_o  (ce_cnt),
      .s_uce_o     (uce_flag),
      .s_uce_add_o (uce_add),
      .s_pass_o    (pass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Returns at the falling edge of the next scrub cycle; n = cycles waited.
   task automatic wait_scrub(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!scrub && n < 200);
      check_eq("scrub_seen", scrub, 1);
   endtask

   task automatic run_to(input logic [4:0] addr);
      int n;
      int k;
      k = 0;
      do begin
         wait_scrub(n);
         k++;
      end while (rp2_add != addr && k < 40);
      check_eq("run_to_addr", rp2_add, addr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int sc;
      logic [4:0] a;
      resetn = 1'b0; en = 1'b0; clr = 1'b0; busy = 1'b0; p2_add = 5'd6;
      ce = 1'b0; uce = 1'b0; we = 1'b0; wadd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_scrub", scrub, 0);
      check_eq("rst_rp2_mux", rp2_add, 6);
      check_eq("rst_cnt", ce_cnt, 0);
      check_eq("rst_uce", uce_flag, 0);
      check_eq("rst_uce_add", uce_add, 0);
      check_eq("rst_pass", pass, 0);

      // Clean sweep: 16 idle cycles between reads, x1..x31 then wrap to x1
      @(posedge clk); #1 resetn = 1'b1; en = 1'b1; p2_add = '0;
      for (int k = 1; k <= 32; k++) begin
         wait_scrub(n);
         check_eq("sweep_gap", n, (k == 1) ? 17 : 16);
         check_eq("sweep_addr", rp2_add, ((k - 1) % 31) + 1);
         @(negedge clk);
         check_eq("sweep_pass", pass, (k == 31) ? 1 : 0);
      end

      // Port contention: pipeline keeps the port through 16 idle + 5 READ cycles
      busy = 1'b1; p2_add = 5'd7;
      for (int i = 0; i <= 20; i++) begin
         #1;
         check_eq("busy_mux", {scrub, rp2_add}, {1'b0, 5'd7});
         if (i < 20) @(negedge clk);
      end
      @(posedge clk); #1 busy = 1'b0;
      @(negedge clk);
      check_eq("busy_release_scrub", scrub, 1);
      check_eq("busy_release_addr", rp2_add, 2);
      p2_add = '0;

      // CE repair at x9: a write to x8 must not count, the write to x9 must
      run_to(5'd9);
      check_eq("ce_cnt_before", ce_cnt, 0);
      ce = 1'b1;
      @(posedge clk); #1 ce = 1'b0; we = 1'b1; wadd = 5'd8;
      @(posedge clk); #1 wadd = 5'd9;
      @(posedge clk); #1 we = 1'b0;
      @(negedge clk);
      check_eq("ce_cnt_after_fix", ce_cnt, 1);
      wait_scrub(n);
      check_eq("fix_next_gap", n, 16);
      check_eq("fix_next_addr", rp2_add, 10);

      // Timeout at x12: 4 waiting cycles, no count
      run_to(5'd12);
      ce = 1'b1;
      @(posedge clk); #1 ce = 1'b0;
      wait_scrub(n);
      check_eq("tmo_gap", n, 21);
      check_eq("tmo_next_addr", rp2_add, 13);
      check_eq("tmo_cnt", ce_cnt, 1);

      // UCE sticky keeps the first address
      run_to(5'd5);
      uce = 1'b1;
      @(posedge clk); #1 uce = 1'b0;
      @(negedge clk);
      check_eq("uce1_flag", uce_flag, 1);
      check_eq("uce1_add", uce_add, 5);
      run_to(5'd20);
      uce = 1'b1;
      @(posedge clk); #1 uce = 1'b0;
      @(negedge clk);
      check_eq("uce2_flag", uce_flag, 1);
      check_eq("uce2_add", uce_add, 5);
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      @(negedge clk);
      check_eq("clr_uce", uce_flag, 0);
      check_eq("clr_uce_add", uce_add, 0);
      check_eq("clr_cnt", ce_cnt, 0);
      run_to(5'd21);
      uce = 1'b1; clr = 1'b1;
      @(posedge clk); #1 uce = 1'b0; clr = 1'b0;
      @(negedge clk);
      check_eq("clr_vs_uce_flag", uce_flag, 0);
      check_eq("clr_vs_uce_add", uce_add, 0);

      // Counter saturates at all-ones; clear beats a simultaneous increment
      for (int k = 1; k <= 17; k++) begin
         wait_scrub(n);
         a = rp2_add;
         ce = 1'b1;
         @(posedge clk); #1 ce = 1'b0; we = 1'b1; wadd = a;
         @(posedge clk); #1 we = 1'b0;
         @(negedge clk);
         check_eq("sat_cnt", ce_cnt, (k > 15) ? 15 : k);
      end
      wait_scrub(n);
      a = rp2_add;
      ce = 1'b1;
      @(posedge clk); #1 ce = 1'b0; we = 1'b1; wadd = a; clr = 1'b1;
      @(posedge clk); #1 we = 1'b0; clr = 1'b0;
      @(negedge clk);
      check_eq("clr_vs_inc_cnt", ce_cnt, 0);

      // Disable while READ waits on the port: finish that read, then park
      wait_scrub(n);
      @(posedge clk); #1 busy = 1'b1;
      repeat (17) @(posedge clk);
      #1 en = 1'b0; busy = 1'b0;
      @(negedge clk);
      check_eq("dis_completes", scrub, 1);
      sc = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (scrub) sc++;
      end
      check_eq("dis_parked", sc, 0);
      @(posedge clk); #1 en = 1'b1;
      wait_scrub(n);
      check_eq("reen_gap", n, 17);

      // Reset in the middle of WAITFIX
      uce = 1'b1;
      @(posedge clk); #1 uce = 1'b0;
      wait_scrub(n);
      a = rp2_add;
      ce = 1'b1;
      @(posedge clk); #1 ce = 1'b0; we = 1'b1; wadd = a;
      @(posedge clk); #1 we = 1'b0;
      wait_scrub(n);
      check_eq("pre_rst_cnt", ce_cnt, 1);
      check_eq("pre_rst_uce", uce_flag, 1);
      ce = 1'b1;
      @(posedge clk); #1 ce = 1'b0; resetn = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_scrub", scrub, 0);
      check_eq("mid_rst_cnt", ce_cnt, 0);
      check_eq("mid_rst_uce", uce_flag, 0);
      check_eq("mid_rst_uce_add", uce_add, 0);
      check_eq("mid_rst_pass", pass, 0);
      wait_scrub(n);
      check_eq("mid_rst_gap", n, 16);
      check_eq("mid_rst_ptr", rp2_add, 1);

      // Repair of x9 followed by a persistent error on the re-read
      run_to(5'd9);
      ce = 1'b1;
      @(posedge clk); #1 ce = 1'b0; we = 1'b1; wadd = 5'd9;
      @(posedge clk); #1 we = 1'b0;
      @(negedge clk);
      check_eq("final_fix_cnt", ce_cnt, 1);
`ifdef HARDISC_SCRUB_VERIFY_EN
      check_eq("verify_scrub", scrub, 1);
      check_eq("verify_addr", rp2_add, 9);
      ce = 1'b1;
      @(posedge clk); #1 ce = 1'b0;
      @(negedge clk);
      check_eq("verify_uce", uce_flag, 1);
      check_eq("verify_uce_add", uce_add, 9);
      wait_scrub(n);
      check_eq("verify_next_addr", rp2_add, 10);
`else
      check_eq("noverify_scrub", scrub, 0);
      wait_scrub(n);
      check_eq("noverify_gap", n, 16);
      check_eq("noverify_next_addr", rp2_add, 10);
      check_eq("noverify_uce", uce_flag, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
